// File: rtl/elbeth_branch_ctrl_pkg.sv
// elbeth_branch_ctrl_pkg: shared definitions for the ID-stage branch controller.
//   - brc_state_e   : branch-controller FSM state encodings
//   - OP_*          : branch/jump operation encodings used by the decoder
//   - brc_op_stall  : stall cycles one source operand needs before it is forwardable
package elbeth_branch_ctrl_pkg;

    typedef enum logic [1:0] {
        BRC_S_IDLE    = 2'd0,
        BRC_S_STALL   = 2'd1,
        BRC_S_RESOLVE = 2'd2
    } brc_state_e;

    localparam logic [2:0] OP_BEQ  = 3'd0;
    localparam logic [2:0] OP_BNE  = 3'd1;
    localparam logic [2:0] OP_BLT  = 3'd2;
    localparam logic [2:0] OP_BGE  = 3'd3;
    localparam logic [2:0] OP_BLTU = 3'd4;
    localparam logic [2:0] OP_BGEU = 3'd5;
    localparam logic [2:0] OP_JAL  = 3'd6;
    localparam logic [2:0] OP_JALR = 3'd7;

    // A MEM-stage non-load result is already on the forwarding path, so it costs
    // nothing; x0 is never a real dependency.
    function automatic logic [1:0] brc_op_stall(
        input logic       uses,
        input logic [4:0] rs,
        input logic [4:0] ex_rd,
        input logic       ex_we,
        input logic       ex_ld,
        input logic [4:0] mem_rd,
        input logic       mem_we,
        input logic       mem_ld,
        input logic [1:0] ex_alu_stall,
        input logic [1:0] ex_load_stall,
        input logic [1:0] mem_load_stall
    );
        logic [1:0] e;
        logic [1:0] m;
        e = (uses && ex_we && ex_rd == rs && ex_rd != 5'd0) ? (ex_ld ? ex_load_stall : ex_alu_stall) : 2'd0;
        m = (uses && mem_we && mem_rd == rs && mem_rd != 5'd0 && mem_ld) ? mem_load_stall : 2'd0;
        return (e > m) ? e : m;
    endfunction

endpackage

// File: rtl/elbeth_branch_ctrl_hazard.sv
// elbeth_branch_hazard: combinational required-stall computation for a branch in ID.
//   inputs : id_uses_rs1/2_i, id_rs1/2_addr_i, ex/mem rd index, reg_write and load flags
//   output : stall_o - stall cycles needed (max over rs1/rs2) before operands forward
module elbeth_branch_hazard
    import elbeth_branch_ctrl_pkg::*;
#(
    parameter int EX_ALU_STALL   = 1,
    parameter int EX_LOAD_STALL  = 2,
    parameter int MEM_LOAD_STALL = 1
) (
    input  logic       id_uses_rs1_i,
    input  logic       id_uses_rs2_i,
    input  logic [4:0] id_rs1_addr_i,
    input  logic [4:0] id_rs2_addr_i,
    input  logic [4:0] ex_rd_addr_i,
    input  logic [4:0] mem_rd_addr_i,
    input  logic       ex_reg_write_i,
    input  logic       mem_reg_write_i,
    input  logic       ex_mem_read_i,
    input  logic       mem_mem_read_i,
    output logic [1:0] stall_o
);
    localparam logic [1:0] EA = 2'(EX_ALU_STALL);
    localparam logic [1:0] EL = 2'(EX_LOAD_STALL);
    localparam logic [1:0] ML = 2'(MEM_LOAD_STALL);

    logic [1:0] s1;
    logic [1:0] s2;

    assign s1 = brc_op_stall(id_uses_rs1_i, id_rs1_addr_i, ex_rd_addr_i, ex_reg_write_i, ex_mem_read_i,
                             mem_rd_addr_i, mem_reg_write_i, mem_mem_read_i, EA, EL, ML);
    assign s2 = brc_op_stall(id_uses_rs2_i, id_rs2_addr_i, ex_rd_addr_i, ex_reg_write_i, ex_mem_read_i,
                             mem_rd_addr_i, mem_reg_write_i, mem_mem_read_i, EA, EL, ML);
    assign stall_o = (s1 > s2) ? s1 : s2;
endmodule

// File: rtl/elbeth_branch_ctrl.sv
// elbeth_branch_ctrl: ID-stage branch sequencer. Stalls IF/ID until branch operands are
// forwardable, then turns the branch unit result into one PC redirect plus IF/ID flush.
//   clk, rst_n (async active-low)           hold_i : global freeze
//   id_* : branch in ID and its operands      ex_*/mem_* : producers in EX/MEM
//   bu_branch_taken_i, bu_pc_branch_i        : branch unit result
//   stall_if_id_o, id_ex_bubble_o            : hold IF/ID, bubble ID/EX
//   pc_redirect_valid_o, pc_redirect_o, if_id_flush_o : redirect on a taken resolve
//   ELBETH_BRANCH_PERF_EN adds perf_branches_o, perf_taken_o, perf_stall_cycles_o.
module elbeth_branch_ctrl
    import elbeth_branch_ctrl_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int EX_ALU_STALL   = 1,
    parameter int EX_LOAD_STALL  = 2,
    parameter int MEM_LOAD_STALL = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            hold_i,
    input  logic            id_valid_i,
    input  logic            id_is_branch_i,
    input  logic            id_uses_rs1_i,
    input  logic            id_uses_rs2_i,
    input  logic [4:0]      id_rs1_addr_i,
    input  logic [4:0]      id_rs2_addr_i,
    input  logic [4:0]      ex_rd_addr_i,
    input  logic [4:0]      mem_rd_addr_i,
    input  logic            ex_reg_write_i,
    input  logic            mem_reg_write_i,
    input  logic            ex_mem_read_i,
    input  logic            mem_mem_read_i,
    input  logic            bu_branch_taken_i,
    input  logic [XLEN-1:0] bu_pc_branch_i,
    output logic            stall_if_id_o,
    output logic            id_ex_bubble_o,
    output logic            pc_redirect_valid_o,
    output logic [XLEN-1:0] pc_redirect_o,
    output logic            if_id_flush_o
`ifdef ELBETH_BRANCH_PERF_EN
    ,
    output logic [31:0]     perf_branches_o,
    output logic [31:0]     perf_taken_o,
    output logic [31:0]     perf_stall_cycles_o
`endif
);
    brc_state_e state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    logic [1:0] req;
    logic       branch;
    logic       stall;
    logic       resolve;
    logic       redirect;

    elbeth_branch_hazard #(
        .EX_ALU_STALL  (EX_ALU_STALL),
        .EX_LOAD_STALL (EX_LOAD_STALL),
        .MEM_LOAD_STALL(MEM_LOAD_STALL)
    ) u_hazard (
        .id_uses_rs1_i  (id_uses_rs1_i),
        .id_uses_rs2_i  (id_uses_rs2_i),
        .id_rs1_addr_i  (id_rs1_addr_i),
        .id_rs2_addr_i  (id_rs2_addr_i),
        .ex_rd_addr_i   (ex_rd_addr_i),
        .mem_rd_addr_i  (mem_rd_addr_i),
        .ex_reg_write_i (ex_reg_write_i),
        .mem_reg_write_i(mem_reg_write_i),
        .ex_mem_read_i  (ex_mem_read_i),
        .mem_mem_read_i (mem_mem_read_i),
        .stall_o        (req)
    );

    assign branch = id_valid_i & id_is_branch_i;

    // The cycle that detects the hazard is itself the first stall cycle, so cnt holds
    // the stall cycles still owed after it; a one-cycle hazard goes straight to resolve.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall   = 1'b0;
        resolve = 1'b0;
        if (!branch) begin
            state_d = BRC_S_IDLE;
            cnt_d   = 2'd0;
        end else if (state_q == BRC_S_STALL) begin
            stall   = 1'b1;
            cnt_d   = (cnt_q <= 2'd1) ? 2'd0 : cnt_q - 2'd1;
            state_d = (cnt_q <= 2'd1) ? BRC_S_RESOLVE : BRC_S_STALL;
        end else if (req != 2'd0) begin
            stall   = 1'b1;
            cnt_d   = req - 2'd1;
            state_d = (req == 2'd1) ? BRC_S_RESOLVE : BRC_S_STALL;
        end else begin
            resolve = 1'b1;
            state_d = BRC_S_IDLE;
        end
        if (hold_i) begin
            state_d = state_q;
            cnt_d   = cnt_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BRC_S_IDLE;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Redirect is suppressed under hold so the PC is only updated once per branch.
    assign redirect            = rst_n & resolve & bu_branch_taken_i & ~hold_i;
    assign stall_if_id_o       = rst_n & stall;
    assign id_ex_bubble_o      = rst_n & stall;
    assign pc_redirect_valid_o = redirect;
    assign if_id_flush_o       = redirect;
    assign pc_redirect_o       = redirect ? bu_pc_branch_i : '0;

`ifdef ELBETH_BRANCH_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_branches_o     <= 32'd0;
            perf_taken_o        <= 32'd0;
            perf_stall_cycles_o <= 32'd0;
        end else if (!hold_i) begin
            if (resolve) perf_branches_o <= perf_branches_o + 32'd1;
            if (resolve && bu_branch_taken_i) perf_taken_o <= perf_taken_o + 32'd1;
            if (branch && state_q == BRC_S_STALL) perf_stall_cycles_o <= perf_stall_cycles_o + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_elbeth_branch_ctrl.sv
// tb_elbeth_branch_ctrl: directed vectors for elbeth_branch_ctrl with a queue-based scoreboard.
module tb_elbeth_branch_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        hold = 1'b0;
    logic        id_valid = 1'b0;
    logic        id_is_branch = 1'b0;
    logic        u1 = 1'b0;
    logic        u2 = 1'b0;
    logic [4:0]  rs1 = '0;
    logic [4:0]  rs2 = '0;
    logic [4:0]  ex_rd = '0;
    logic [4:0]  mem_rd = '0;
    logic        ex_we = 1'b0;
    logic        mem_we = 1'b0;
    logic        ex_ld = 1'b0;
    logic        mem_ld = 1'b0;
    logic        taken = 1'b0;
    logic [31:0] target = '0;
    logic        stall_if_id;
    logic        id_ex_bubble;
    logic        pc_redirect_valid;
    logic [31:0] pc_redirect;
    logic        if_id_flush;

    typedef struct {
        string       name;
        logic [35:0] exp;
    } exp_t;

    exp_t        sb[$];
    exp_t        cur;
    logic [35:0] got;
    int          n_vec = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    elbeth_branch_ctrl dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .hold_i             (hold),
        .id_valid_i         (id_valid),
        .id_is_branch_i     (id_is_branch),
        .id_uses_rs1_i      (u1),
        .id_uses_rs2_i      (u2),
        .id_rs1_addr_i      (rs1),
        .id_rs2_addr_i      (rs2),
        .ex_rd_addr_i       (ex_rd),
        .mem_rd_addr_i      (mem_rd),
        .ex_reg_write_i     (ex_we),
        .mem_reg_write_i    (mem_we),
        .ex_mem_read_i      (ex_ld),
        .mem_mem_read_i     (mem_ld),
        .bu_branch_taken_i  (taken),
        .bu_pc_branch_i     (target),
        .stall_if_id_o      (stall_if_id),
        .id_ex_bubble_o     (id_ex_bubble),
        .pc_redirect_valid_o(pc_redirect_valid),
        .pc_redirect_o      (pc_redirect),
        .if_id_flush_o      (if_id_flush)
    );

    // Apply one cycle of inputs just after the edge and queue what must appear that cycle.
    task automatic vec(input string nm, input logic r, h, v, b, a1, a2,
                       input logic [4:0] s1, s2, erd, input logic ewe, eld,
                       input logic [4:0] mrd, input logic mwe, mld, tk,
                       input logic [31:0] tgt, input logic es, erv, input logic [31:0] epc);
        @(posedge clk);
        #1;
        rst_n = r; hold = h; id_valid = v; id_is_branch = b; u1 = a1; u2 = a2;
        rs1 = s1; rs2 = s2; ex_rd = erd; ex_we = ewe; ex_ld = eld;
        mem_rd = mrd; mem_we = mwe; mem_ld = mld; taken = tk; target = tgt;
        sb.push_back('{nm, {es, es, erv, erv, epc}});
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            cur = sb.pop_front();
            got = {stall_if_id, id_ex_bubble, pc_redirect_valid, if_id_flush, pc_redirect};
            n_vec++;
            if (got !== cur.exp) begin
                n_bad++;
                $display("FAIL %s: got stall/bubble/rv/flush/pc=%h required %h", cur.name, got, cur.exp);
            end
        end
    end

    initial begin
        //  name              rst hld vld br u1 u2 rs1 rs2 exrd we ld mrd we ld tk target      st rv pc
        vec("reset_hazard",    0, 0, 1, 1, 1, 0, 5, 0, 5, 1, 1, 0, 0, 0, 1, 32'h0000_0100, 0, 0, 32'h0);
        vec("beq_nohaz_taken", 1, 0, 1, 1, 1, 1, 1, 2, 0, 0, 0, 0, 0, 0, 1, 32'h0000_0100, 0, 1, 32'h100);
        vec("idle_no_valid",   1, 0, 0, 1, 1, 0, 5, 0, 5, 1, 1, 0, 0, 0, 1, 32'h0000_0700, 0, 0, 32'h0);
        vec("bne_exld_c1",     1, 0, 1, 1, 1, 0, 5, 0, 5, 1, 1, 0, 0, 0, 0, 32'h0000_0200, 1, 0, 32'h0);
        vec("bne_exld_c2",     1, 0, 1, 1, 1, 0, 5, 0, 0, 0, 0, 5, 1, 1, 0, 32'h0000_0200, 1, 0, 32'h0);
        vec("bne_resolve_nt",  1, 0, 1, 1, 1, 0, 5, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0000_0200, 0, 0, 32'h0);
        vec("blt_max_c1",      1, 0, 1, 1, 0, 1, 0, 7, 7, 1, 0, 7, 1, 1, 1, 32'h0000_0300, 1, 0, 32'h0);
        vec("blt_resolve_tk",  1, 0, 1, 1, 0, 1, 0, 7, 0, 0, 0, 7, 1, 0, 1, 32'h0000_0300, 0, 1, 32'h300);
        vec("x0_no_stall",     1, 0, 1, 1, 1, 0, 0, 0, 0, 1, 1, 0, 1, 1, 1, 32'h0000_0044, 0, 1, 32'h44);
        vec("mem_alu_fwd",     1, 0, 1, 1, 1, 0, 3, 0, 0, 0, 0, 3, 1, 0, 1, 32'h0000_0048, 0, 1, 32'h48);
        vec("unused_rs2",      1, 0, 1, 1, 1, 0, 4, 9, 9, 1, 1, 0, 0, 0, 1, 32'h0000_004c, 0, 1, 32'h4c);
        vec("not_branch",      1, 0, 1, 0, 1, 0, 5, 0, 5, 1, 1, 0, 0, 0, 1, 32'h0000_0050, 0, 0, 32'h0);
        vec("hold_c1",         1, 0, 1, 1, 1, 0, 5, 0, 5, 1, 1, 0, 0, 0, 1, 32'h0000_0500, 1, 0, 32'h0);
        vec("hold_frz1",       1, 1, 1, 1, 1, 0, 5, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0000_0500, 1, 0, 32'h0);
        vec("hold_frz2",       1, 1, 1, 1, 1, 0, 5, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0000_0500, 1, 0, 32'h0);
        vec("hold_frz3",       1, 1, 1, 1, 1, 0, 5, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0000_0500, 1, 0, 32'h0);
        vec("hold_last_stall", 1, 0, 1, 1, 1, 0, 5, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0000_0500, 1, 0, 32'h0);
        vec("hold_on_resolve", 1, 1, 1, 1, 1, 0, 5, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0000_0500, 0, 0, 32'h0);
        vec("hold_resolve_tk", 1, 0, 1, 1, 1, 0, 5, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0000_0500, 0, 1, 32'h500);
        vec("defensive_c1",    1, 0, 1, 1, 1, 0, 7, 0, 7, 1, 0, 0, 0, 0, 1, 32'h0000_0600, 1, 0, 32'h0);
        vec("defensive_rest",  1, 0, 1, 1, 1, 0, 7, 0, 7, 1, 0, 0, 0, 0, 1, 32'h0000_0600, 1, 0, 32'h0);
        vec("defensive_res",   1, 0, 1, 1, 1, 0, 7, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0000_0600, 0, 1, 32'h600);
        vec("rst_mid_c1",      1, 0, 1, 1, 1, 0, 5, 0, 5, 1, 1, 0, 0, 0, 1, 32'h0000_0800, 1, 0, 32'h0);
        vec("rst_mid_assert",  0, 0, 1, 1, 1, 0, 5, 0, 5, 1, 1, 0, 0, 0, 1, 32'h0000_0800, 0, 0, 32'h0);
        vec("rst_after_idle",  1, 0, 1, 1, 1, 0, 5, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0000_0900, 0, 1, 32'h900);
        vec("final_idle",      1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0000_0000, 0, 0, 32'h0);
        repeat (3) @(posedge clk);
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
